// File: rtl/led_snake_sequencer.sv
// Purpose : step/reload controller for the switch-selected LED snake shifter
//           (free-run, pause/resume, single step, debounced length change).
// Latency : every output is registered; a decision made on edge N is visible after edge N.
// Ports   : clk, rst (sync, active-high), run (level), step_req (button), switch[2:0]
//           -> step_o, load_o (1-cycle pulses), len_sel[2:0], state_o[1:0], steps[7:0].
module led_snake_sequencer #(
  parameter int TICK_DIV = 4,  // cycles between auto steps in RUN (>= 2)
  parameter int DEBOUNCE = 3   // stable cycles before a switch change is accepted (>= 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step_req,
  input  logic [2:0] switch,
  output logic       step_o,
  output logic       load_o,
  output logic [2:0] len_sel,
  output logic [1:0] state_o,
  output logic [7:0] steps
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HOLD   = 2'b10,
    S_RELOAD = 2'b11
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  sw_cnt_q, sw_cnt_d;
  logic [2:0]     sw_last_q;
  logic           req_prev_q;
  logic           step_q, step_d;
  logic           load_q, load_d;
  logic [2:0]     len_q, len_d;
  logic [7:0]     steps_q, steps_d;

  logic rise;
  logic reload_req;

  assign rise       = step_req & ~req_prev_q;
  // A reload is never re-triggered from inside the one-cycle RELOAD state.
  assign reload_req = (sw_cnt_q == SW'(DEBOUNCE)) && (state_q != S_RELOAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    load_d  = 1'b0;
    len_d   = len_q;
    steps_d = steps_q;

    // Debounce: count consecutive cycles the switch holds a new value
    // that differs from the accepted length; saturate at the threshold.
    if ((switch != sw_last_q) || (switch == len_q)) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q == SW'(DEBOUNCE)) begin
      sw_cnt_d = sw_cnt_q;
    end else begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end

    if (reload_req) begin
      // Reload wins over any coincident button edge or RUN tick.
      state_d  = S_RELOAD;
      len_d    = switch;
      load_d   = 1'b1;
      cnt_d    = '0;
      steps_d  = '0;
      sw_cnt_d = '0;
    end else begin
      case (state_q)
        S_RELOAD: begin
          cnt_d   = '0;
          state_d = run ? S_RUN : S_IDLE;
        end
        S_IDLE: begin
          if (run) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else if (rise) begin
            step_d  = 1'b1;
            steps_d = steps_q + 8'd1;
          end
        end
        S_RUN: begin
          if (!run) begin
            state_d = S_IDLE;
          end else if (rise) begin
            state_d = S_HOLD;
          end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_d   = '0;
            step_d  = 1'b1;
            steps_d = steps_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          // cnt stays frozen so a resume continues the interrupted interval.
          if (!run) begin
            state_d = S_IDLE;
          end else if (rise) begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sw_cnt_q   <= '0;
      sw_last_q  <= '0;
      req_prev_q <= 1'b0;
      step_q     <= 1'b0;
      load_q     <= 1'b0;
      len_q      <= '0;
      steps_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sw_cnt_q   <= sw_cnt_d;
      sw_last_q  <= switch;
      req_prev_q <= step_req;
      step_q     <= step_d;
      load_q     <= load_d;
      len_q      <= len_d;
      steps_q    <= steps_d;
    end
  end

  assign step_o  = step_q;
  assign load_o  = load_q;
  assign len_sel = len_q;
  assign state_o = state_q;
  assign steps   = steps_q;

endmodule
